spi_slave: RTL

- SPI peripheral (slave) endpoint; the responder for spi_master, in the same SPI subsystem.
- Oversamples chip-select, SPI clock and MOSI with the system clock.
- Shifts out a parallel TX byte on MISO while shifting in the MOSI byte, MSB first.
- Presents each received byte with a one-cycle valid strobe; supports back-to-back bytes within one CS-low frame.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI mode and FSM state encodings
package spi_pkg;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } spi_state_e;

    // Sample edge is the falling SCLK edge when CPOL and CPHA differ.
    function automatic logic sample_on_fall(input logic [1:0] mode);
        case (mode)
            SPI_MODE0, SPI_MODE3: return 1'b0;
            SPI_MODE1, SPI_MODE2: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - 2-FF synchronizer with rise/fall strobes
module spi_sync_edge #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave endpoint with back-to-back word support
module spi_slave
    import spi_pkg::*;
#(
    parameter bit clkPolarity = 1'b0,
    parameter bit clkPhase    = 1'b0,
    parameter int dataWidth   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cs_i,
    input  logic                 spiClk_i,
    input  logic                 mosi_i,
    output logic                 miso_o,
    output logic                 miso_en_o,
    input  logic [dataWidth-1:0] tx_data_i,
    output logic                 tx_ack_o,
    output logic [dataWidth-1:0] rx_data_o,
    output logic                 rx_valid_o,
    output logic                 busy_o,
    output logic                 frame_err_o
);

    localparam logic [1:0]       MODE        = {clkPolarity, clkPhase};
    localparam bit               SAMPLE_FALL = sample_on_fall(MODE);
    localparam int               CNT_W       = (dataWidth > 1) ? $clog2(dataWidth) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(dataWidth - 1);

    logic cs_sync, cs_rise, cs_fall;
    logic sclk_sync, sclk_rise, sclk_fall;
    logic mosi_meta_q, mosi_sync_q;
    logic sample_edge;
    logic unused_levels;

    spi_state_e             state_q, state_d;
    logic [dataWidth-1:0]   tx_shift_q, tx_shift_d;
    logic [dataWidth-2:0]   rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [dataWidth-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ack_q, tx_ack_d;
    logic                   frame_err_q, frame_err_d;
    logic [dataWidth-1:0]   rx_word;

    spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cs_i),
        .sync_o (cs_sync),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_sync_edge #(.RESET_VAL(clkPolarity)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (spiClk_i),
        .sync_o (sclk_sync),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            mosi_meta_q <= mosi_i;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign unused_levels = cs_sync ^ sclk_sync;
    assign sample_edge   = SAMPLE_FALL ? sclk_fall : sclk_rise;
    assign rx_word       = {rx_shift_q, mosi_sync_q};

    // MISO advances right after each synchronized sample edge and the MSB is
    // presented at load time: waiting for the synchronized shift edge would land
    // after the master's next sample edge at the 4x clock ratio.
    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_ack_d    = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else begin
                    tx_shift_d = tx_data_i;
                    tx_ack_d   = 1'b1;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    tx_shift_d  = '0;
                    rx_shift_d  = '0;
                end else if (sample_edge) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        tx_shift_d = tx_data_i;
                        tx_ack_d   = 1'b1;
                    end else begin
                        rx_shift_d = rx_word[dataWidth-2:0];
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                        tx_shift_d = {tx_shift_q[dataWidth-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ack_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ack_q    <= tx_ack_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign miso_en_o   = (state_q != ST_IDLE);
    assign miso_o      = (state_q == ST_SHIFT) & tx_shift_q[dataWidth-1];
    assign tx_ack_o    = tx_ack_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign frame_err_o = frame_err_q;

endmodule
